// File: rtl/delay_config_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : beamformer_pkg
// Purpose  : Shared sizing constants and FSM state encoding for the delay
//            configuration controller of the beamformer.
// Revision : 1.0  initial release
// ============================================================================
package beamformer_pkg;

  // Depth of each per-channel delay buffer; legal delays are 0..BUFFER_SIZE-1.
  localparam int BUFFER_SIZE       = 10;
  // One extra bit so that out-of-range delays (>= BUFFER_SIZE) are representable
  // and can be detected and rejected rather than silently wrapping.
  localparam int INDEX_WIDTH       = $clog2(BUFFER_SIZE) + 1;
  localparam int CHANNEL_SEL_WIDTH = 3;
  localparam int WORD_BITS         = CHANNEL_SEL_WIDTH + INDEX_WIDTH;
  // Length of one serial configuration word as seen by beamformer blocks.
  localparam int NUMBER_OF_BITS    = WORD_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage : beamformer_pkg
`default_nettype wire

// File: rtl/delay_config_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : delay_config_controller_if
// Purpose  : Serial configuration port, frame strobe and delay/status outputs
//            of the delay configuration controller.
// Revision : 1.0  initial release
// ============================================================================
interface delay_config_controller_if #(
  parameter int NUMBER_OF_CHANNELS = 8,
  parameter int INDEX_WIDTH        = beamformer_pkg::INDEX_WIDTH
) ();

  logic                                       cfg_sclk;
  logic                                       cfg_data;
  logic                                       cfg_en;
  logic                                       ws;
  logic [NUMBER_OF_CHANNELS*INDEX_WIDTH-1:0]  read_index;
  logic                                       pending;
  logic                                       commit_pulse;
  logic                                       cfg_error;
  logic                                       busy;

  // Configuration host / frame source side
  modport master (
    output cfg_sclk, cfg_data, cfg_en, ws,
    input  read_index, pending, commit_pulse, cfg_error, busy
  );

  // Controller side
  modport slave (
    input  cfg_sclk, cfg_data, cfg_en, ws,
    output read_index, pending, commit_pulse, cfg_error, busy
  );

endinterface : delay_config_controller_if
`default_nettype wire

// File: rtl/delay_config_controller_sync.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : Two-flop synchronizer for an asynchronous input with rising and
//            falling edge strobes derived against one further registered copy.
// Revision : 1.0  initial release
// ============================================================================
module sync_edge_detect (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_async,
  output logic      o_sync,
  output logic      o_rise,
  output logic      o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/delay_config_controller.sv
`default_nettype none
// ============================================================================
// Module   : delay_config_controller
// Purpose  : Receives serial per-channel delay words into a shadow bank and
//            commits the whole bank to the active delays on an I2S frame
//            boundary, so all channels switch delay on the same sample.
// Revision : 1.0  initial release
// ============================================================================
module delay_config_controller #(
  parameter int NUMBER_OF_CHANNELS = 8,
  parameter int BUFFER_SIZE        = beamformer_pkg::BUFFER_SIZE,
  parameter int INDEX_WIDTH        = $clog2(BUFFER_SIZE) + 1
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  delay_config_controller_if.slave   cfg_bus
);

  import beamformer_pkg::state_t;
  import beamformer_pkg::IDLE;
  import beamformer_pkg::SHIFT;
  import beamformer_pkg::CHECK;

  localparam int c_CHAN_W    = beamformer_pkg::CHANNEL_SEL_WIDTH;
  localparam int c_WORD_BITS = c_CHAN_W + INDEX_WIDTH;
  localparam int c_CNT_W     = $clog2(c_WORD_BITS + 2);
  localparam logic [c_CNT_W-1:0] c_CNT_WORD = c_CNT_W'(c_WORD_BITS);
  // Saturation point: one past a full word is enough to flag "too long".
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(c_WORD_BITS + 1);

  // Synchronized control strobes
  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_en_sync,   w_en_rise,   w_en_fall;
  logic w_ws_sync,   w_ws_rise,   w_ws_fall;

  sync_edge_detect u_sync_sclk (
    .clk     (clk),
    .reset   (reset),
    .i_async (cfg_bus.cfg_sclk),
    .o_sync  (w_sclk_sync),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  sync_edge_detect u_sync_en (
    .clk     (clk),
    .reset   (reset),
    .i_async (cfg_bus.cfg_en),
    .o_sync  (w_en_sync),
    .o_rise  (w_en_rise),
    .o_fall  (w_en_fall)
  );

  sync_edge_detect u_sync_ws (
    .clk     (clk),
    .reset   (reset),
    .i_async (cfg_bus.ws),
    .o_sync  (w_ws_sync),
    .o_rise  (w_ws_rise),
    .o_fall  (w_ws_fall)
  );

  // Level and unused-edge outputs of the synchronizers are not needed here.
  logic w_unused_sync;
  assign w_unused_sync = &{1'b0, w_sclk_sync, w_sclk_fall, w_en_sync, w_ws_sync, w_ws_fall};

  logic r_data_meta;
  logic r_data_sync;

  // Data only needs level synchronization; it has the same two-flop delay as
  // the sclk path, so data and its strobe stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_meta <= 1'b0;
      r_data_sync <= 1'b0;
    end else begin
      r_data_meta <= cfg_bus.cfg_data;
      r_data_sync <= r_data_meta;
    end
  end

  state_t                   r_state;
  state_t                   w_state_next;
  logic [c_WORD_BITS-1:0]   r_shift;
  logic [c_CNT_W-1:0]       r_bit_cnt;
  logic [INDEX_WIDTH-1:0]   r_shadow [NUMBER_OF_CHANNELS];
  logic [INDEX_WIDTH-1:0]   r_active [NUMBER_OF_CHANNELS];
  logic                     r_pending;
  logic                     r_commit_pulse;
  logic                     r_cfg_error;

  logic [c_CHAN_W-1:0]      w_channel;
  logic [INDEX_WIDTH-1:0]   w_delay;
  logic                     w_accept;
  logic                     w_reject;
  logic                     w_commit;

  assign w_channel = r_shift[c_WORD_BITS-1 -: c_CHAN_W];
  assign w_delay   = r_shift[INDEX_WIDTH-1:0];

  // Word validation is only meaningful during the single CHECK cycle.
  always_comb begin
    w_accept = 1'b0;
    w_reject = 1'b0;
    if (r_state == CHECK) begin
      if ((r_bit_cnt == c_CNT_WORD) &&
          (32'(w_channel) < NUMBER_OF_CHANNELS) &&
          (32'(w_delay) <= BUFFER_SIZE - 1)) begin
        w_accept = 1'b1;
      end else begin
        w_reject = 1'b1;
      end
    end
  end

  assign w_commit = w_ws_rise & r_pending;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_en_rise) w_state_next = SHIFT;
      SHIFT:   if (w_en_fall) w_state_next = CHECK;
      CHECK:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Serial word capture; an sclk edge coinciding with the end of the word is
  // dropped so the bit count reflects only edges seen inside the enable window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if ((r_state == IDLE) && w_en_rise) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if ((r_state == SHIFT) && !w_en_fall && w_sclk_rise) begin
      r_shift <= {r_shift[c_WORD_BITS-2:0], r_data_sync};
      if (r_bit_cnt != c_CNT_MAX) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Shadow bank, pending flag and sticky error. A write accepted in the same
  // cycle as a commit wins the pending flag so it goes out on the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUMBER_OF_CHANNELS; n++) begin
        r_shadow[n] <= '0;
      end
      r_pending   <= 1'b0;
      r_cfg_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shadow[w_channel] <= w_delay;
        r_pending           <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
      if (w_reject) begin
        r_cfg_error <= 1'b1;
      end
    end
  end

  // Active bank copies the pre-write shadow on a frame boundary with a pending
  // update; the commit strobe marks the cycle the new delays appear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUMBER_OF_CHANNELS; n++) begin
        r_active[n] <= '0;
      end
      r_commit_pulse <= 1'b0;
    end else begin
      r_commit_pulse <= w_commit;
      if (w_commit) begin
        for (int n = 0; n < NUMBER_OF_CHANNELS; n++) begin
          r_active[n] <= r_shadow[n];
        end
      end
    end
  end

  logic [NUMBER_OF_CHANNELS*INDEX_WIDTH-1:0] w_read_index;

  // Flatten the active bank onto the output bus, channel n at field n.
  always_comb begin
    w_read_index = '0;
    for (int n = 0; n < NUMBER_OF_CHANNELS; n++) begin
      w_read_index[n*INDEX_WIDTH +: INDEX_WIDTH] = r_active[n];
    end
  end

  assign cfg_bus.read_index   = w_read_index;
  assign cfg_bus.pending      = r_pending;
  assign cfg_bus.commit_pulse = r_commit_pulse;
  assign cfg_bus.cfg_error    = r_cfg_error;
  assign cfg_bus.busy         = (r_state != IDLE);

endmodule : delay_config_controller
`default_nettype wire

// File: tb/tb_delay_config_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_config_controller
// Purpose  : Directed self-checking bench for delay_config_controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_delay_config_controller;

  localparam int NCH = 8;
  localparam int IW  = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  delay_config_controller_if #(.NUMBER_OF_CHANNELS(NCH), .INDEX_WIDTH(IW)) bus ();

  delay_config_controller #(
    .NUMBER_OF_CHANNELS (NCH),
    .BUFFER_SIZE        (10),
    .INDEX_WIDTH        (IW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cfg_bus (bus)
  );

  int checks  = 0;
  int errors  = 0;
  int commits = 0;
  logic [NCH*IW-1:0] exp_ri;

  // Count commit strobes away from the active edge.
  always @(negedge clk) begin
    if (bus.commit_pulse === 1'b1) commits++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serial word, MSB first; optionally raise ws one clock after cfg_en drops so
  // the frame boundary lands on the CHECK cycle.
  task automatic send_word(input logic [15:0] w, input int n, input bit coincide);
    bus.cfg_en = 1'b1;
    cycles(4);
    chk("busy_in_shift", bus.busy, 1'b1);
    for (int i = n - 1; i >= 0; i--) begin
      bus.cfg_data = w[i];
      bus.cfg_sclk = 1'b0;
      cycles(3);
      bus.cfg_sclk = 1'b1;
      cycles(3);
    end
    bus.cfg_sclk = 1'b0;
    cycles(3);
    bus.cfg_en = 1'b0;
    if (coincide) begin
      cycles(1);
      bus.ws = 1'b1;
    end
    cycles(6);
  endtask

  task automatic ws_frame();
    bus.ws = 1'b1;
    cycles(6);
    bus.ws = 1'b0;
    cycles(6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_sclk = 1'b0;
    bus.cfg_data = 1'b0;
    bus.cfg_en   = 1'b0;
    bus.ws       = 1'b0;
    reset        = 1'b1;
    exp_ri       = '0;
    cycles(3);

    // Reset state
    chk("rst_read_index", bus.read_index, '0);
    chk("rst_pending", bus.pending, 1'b0);
    chk("rst_commit", bus.commit_pulse, 1'b0);
    chk("rst_error", bus.cfg_error, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    cycles(2);

    // First frame after reset with no writes: nothing to commit
    commits = 0;
    ws_frame();
    chk("no_commit_after_reset", commits, 0);
    chk("ri_after_empty_frame", bus.read_index, '0);

    // ch2 = 7 with latency checks
    send_word(16'b010_00111, 8, 1'b0);
    chk("pending_before_ws", bus.pending, 1'b1);
    chk("no_error_valid", bus.cfg_error, 1'b0);
    exp_ri[2*IW +: IW] = 5'd7;
    commits = 0;
    bus.ws = 1'b1;
    cycles(2);
    chk("ri_edge2_old", bus.read_index, '0);
    chk("commit_edge2_low", bus.commit_pulse, 1'b0);
    cycles(1);
    chk("ri_edge3_new", bus.read_index, exp_ri);
    chk("commit_edge3_high", bus.commit_pulse, 1'b1);
    chk("pending_cleared", bus.pending, 1'b0);
    cycles(1);
    chk("commit_edge4_low", bus.commit_pulse, 1'b0);
    cycles(4);
    bus.ws = 1'b0;
    cycles(6);
    chk("single_commit_ch2", commits, 1);

    // ch1 = 10 is out of range
    send_word(16'b001_01010, 8, 1'b0);
    chk("error_bad_delay", bus.cfg_error, 1'b1);
    chk("pending_bad_delay", bus.pending, 1'b0);
    commits = 0;
    ws_frame();
    chk("ri_unchanged_bad_delay", bus.read_index, exp_ri);
    chk("no_commit_bad_delay", commits, 0);

    // Short and long words rejected, then a valid ch0 = 3
    send_word(16'b010_0101, 7, 1'b0);
    send_word(16'b0_1100_0100, 9, 1'b0);
    chk("pending_short_long", bus.pending, 1'b0);
    chk("error_short_long", bus.cfg_error, 1'b1);
    send_word(16'b000_00011, 8, 1'b0);
    chk("pending_ch0_3", bus.pending, 1'b1);
    ws_frame();
    exp_ri[0 +: IW] = 5'd3;
    chk("ri_ch0_3", bus.read_index, exp_ri);

    // Two writes to ch0 in one frame: last wins, one commit
    send_word(16'b000_00100, 8, 1'b0);
    send_word(16'b000_01001, 8, 1'b0);
    commits = 0;
    ws_frame();
    exp_ri[0 +: IW] = 5'd9;
    chk("ri_ch0_last_wins", bus.read_index, exp_ri);
    chk("single_commit_two_writes", commits, 1);

    // Accept coincident with frame boundary
    send_word(16'b000_00101, 8, 1'b0);
    chk("pending_ch0_5", bus.pending, 1'b1);
    commits = 0;
    send_word(16'b000_00110, 8, 1'b1);
    exp_ri[0 +: IW] = 5'd5;
    chk("ri_coincide_old", bus.read_index, exp_ri);
    chk("pending_coincide", bus.pending, 1'b1);
    chk("commit_coincide", commits, 1);
    bus.ws = 1'b0;
    cycles(6);
    commits = 0;
    ws_frame();
    exp_ri[0 +: IW] = 5'd6;
    chk("ri_coincide_next", bus.read_index, exp_ri);
    chk("pending_after_next", bus.pending, 1'b0);
    chk("commit_next", commits, 1);

    // Reset in the middle of a word
    bus.cfg_en = 1'b1;
    cycles(4);
    for (int i = 0; i < 4; i++) begin
      bus.cfg_data = 1'b1;
      bus.cfg_sclk = 1'b0;
      cycles(3);
      bus.cfg_sclk = 1'b1;
      cycles(3);
    end
    reset = 1'b1;
    cycles(2);
    chk("midrst_read_index", bus.read_index, '0);
    chk("midrst_pending", bus.pending, 1'b0);
    chk("midrst_commit", bus.commit_pulse, 1'b0);
    chk("midrst_error", bus.cfg_error, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    bus.cfg_en   = 1'b0;
    bus.cfg_sclk = 1'b0;
    reset        = 1'b0;
    cycles(4);
    commits = 0;
    ws_frame();
    chk("midrst_no_commit", commits, 0);
    chk("midrst_ri_zero", bus.read_index, '0);
    chk("midrst_no_error", bus.cfg_error, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_delay_config_controller
`default_nettype wire

// File: doc/delay_config_controller.md
DELAY_CONFIG_CONTROLLER -- requirements
Module: delay_config_controller

Interface
REQ-001 Parameter NUMBER_OF_CHANNELS, default 8, number of delay channels (max 8, 3-bit channel field).
REQ-002 Parameter BUFFER_SIZE, default 10, depth of each channel buffer; legal delay 0..BUFFER_SIZE-1.
REQ-003 Parameter INDEX_WIDTH, default $clog2(BUFFER_SIZE)+1 (=5), width of one read index.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cfg_sclk  input  1  asynchronous serial config clock; data captured on its rising edge.
REQ-007 cfg_data  input  1  asynchronous serial config data, MSB first.
REQ-008 cfg_en  input  1  asynchronous word enable; high brackets one config word.
REQ-009 ws  input  1  I2S word select; rising edge marks frame boundary (commit point).
REQ-010 read_index  output  NUMBER_OF_CHANNELS*INDEX_WIDTH  active delays, channel n at bits [n*INDEX_WIDTH +: INDEX_WIDTH].
REQ-011 pending  output  1  shadow holds an uncommitted write.
REQ-012 commit_pulse  output  1  one-cycle pulse when shadow copied to active.
REQ-013 cfg_error  output  1  sticky; set on any rejected word, cleared only by reset.
REQ-014 busy  output  1  high while FSM not IDLE.

Function
REQ-015 cfg_sclk, cfg_data, cfg_en, ws SHALL each pass a 2-flop synchronizer; edges detected on synchronized versions vs. one further registered copy.
REQ-016 Config word = 3-bit channel (MSB first) then INDEX_WIDTH-bit delay (MSB first); total WORD_BITS = 3+INDEX_WIDTH (=8).
REQ-017 FSM states: IDLE, SHIFT, CHECK.
REQ-018 IDLE -> SHIFT on synchronized cfg_en rising edge; shift register and bit counter cleared on entry.
REQ-019 In SHIFT, each synchronized cfg_sclk rising edge shifts synchronized cfg_data into LSB and increments bit counter; counter saturates at WORD_BITS+1.
REQ-020 SHIFT -> CHECK on synchronized cfg_en falling edge; sclk edge in the same cycle is ignored.
REQ-021 CHECK (one cycle) accepts word iff bit count == WORD_BITS, channel < NUMBER_OF_CHANNELS, delay <= BUFFER_SIZE-1; then -> IDLE.
REQ-022 Accepted word: shadow[channel] <= delay, pending <= 1 on exit from CHECK.
REQ-023 Rejected word (short, long, bad channel, delay >= BUFFER_SIZE): shadow unchanged, cfg_error <= 1.
REQ-024 Frame boundary = synchronized ws rising edge; if pending, all shadow entries copy to active in that cycle, pending <= 0, commit_pulse high for exactly that cycle.
REQ-025 Frame boundary with pending=0: no copy, no commit_pulse.
REQ-026 Latency: read_index changes 3 clk edges after first edge sampling ws=1 (2 sync + 1 detect).
REQ-027 Accept in CHECK coincident with frame boundary: commit uses pre-write shadow; new write lands in shadow, pending stays 1 for next frame.
REQ-028 Active registers change only on commit; read_index glitch-free and constant between frames.
REQ-029 Multiple accepted writes within one frame: last write per channel wins; all commit together.

Reset
REQ-030 On reset: FSM IDLE, shift reg/bit counter 0, all shadow and active entries 0, read_index 0, pending 0, commit_pulse 0, cfg_error 0, busy 0, synchronizer flops 0.
REQ-031 Reset mid-SHIFT discards partial word; no shadow write, no error.
REQ-032 First ws edge after reset deassertion with no writes produces no commit_pulse.

Structure
REQ-033 Shared package beamformer_pkg holds NUMBER_OF_BITS, BUFFER_SIZE, INDEX_WIDTH, CHANNEL_SEL_WIDTH (=3), WORD_BITS, and FSM state enum.
REQ-034 One sub-module sync_edge_detect (2-flop sync + rising/falling edge outputs), instantiated for cfg_sclk, cfg_en, ws; cfg_data uses plain 2-flop sync.
REQ-035 Shadow and active banks as NUMBER_OF_CHANNELS x INDEX_WIDTH register arrays; no memory macros.

Verification
REQ-036 Write ch2=7 (bits 010_00111), then ws rise -> pending=1 before, read_index[2]=7 after 3 clk edges, commit_pulse one cycle, pending=0.
REQ-037 Write ch1=10 (delay = BUFFER_SIZE) -> cfg_error=1, pending=0, read_index unchanged after ws rise.
REQ-038 7-bit and 9-bit words -> cfg_error=1, shadow unchanged; subsequent valid ch0=3 still commits 3.
REQ-039 Writes ch0=4 then ch0=9 in one frame -> after ws rise read_index[0]=9, single commit_pulse.
REQ-040 CHECK accept coincident with ws edge -> old value committed, pending stays 1, new value committed at next ws rise.
REQ-041 reset asserted after 4 bits of a word -> all outputs 0; following ws rise gives no commit_pulse.
